// File: rtl/clk_div_multi_if.sv
// Configuration bus for clk_div_multi: write strobe, target channel,
// new period/high-time, and the per-channel "shadow pending" status.
interface clk_div_multi_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 8,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic                 we;
    logic [CH_W-1:0]      ch;
    logic [CNT_WIDTH-1:0] div;
    logic [CNT_WIDTH-1:0] high;
    logic [NUM_CH-1:0]    pend;

    // Configuration source (CPU / register block side)
    modport master (output we, ch, div, high, input pend);
    // Divider side
    modport slave  (input we, ch, div, high, output pend);
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel has an active period/high-time pair plus a shadow pair that is
// only promoted at a period boundary, so reconfiguration never produces a
// truncated or stretched high phase. sync_i forces a boundary on all channels.
module clk_div_multi #(
    parameter int NUM_CH    = 4,
    parameter int CNT_WIDTH = 8,
    parameter int RST_DIV   = 2,
    parameter int RST_HIGH  = 1,
    parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    clk_div_multi_if.slave       cfg,
    input  logic [NUM_CH-1:0]    en_i,
    input  logic                 sync_i,
    output logic [NUM_CH-1:0]    dclk_o,
    output logic [NUM_CH-1:0]    tick_o
);

    localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] RST_CNT_V = CNT_WIDTH'(RST_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] RST_DIV_V = CNT_WIDTH'(RST_DIV);
    localparam logic [CNT_WIDTH-1:0] RST_HI_V  = CNT_WIDTH'(RST_HIGH);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_WIDTH-1:0] cnt_reg,   cnt_next;
            logic [CNT_WIDTH-1:0] div_reg,   div_next;
            logic [CNT_WIDTH-1:0] high_reg,  high_next;
            logic [CNT_WIDTH-1:0] sdiv_reg,  sdiv_next;
            logic [CNT_WIDTH-1:0] shigh_reg, shigh_next;
            logic                 pend_reg,  pend_next;
            logic                 dclk_reg,  dclk_next;
            logic                 tick_reg,  tick_next;
            logic [CNT_WIDTH-1:0] cnt_inc;
            logic                 wr;
            logic                 bnd;

            // Channel indices beyond NUM_CH never match any generated channel.
            assign wr      = cfg.we && (cfg.ch == CH_W'(gi));
            assign cnt_inc = cnt_reg + ONE;
            // A stopped channel (div 0) sits on a boundary every enabled cycle
            // so a pending nonzero period starts it on the very next edge.
            assign bnd     = sync_i ||
                             (en_i[gi] && ((div_reg == '0) || (cnt_reg == div_reg - ONE)));

            // Next-state: shadow capture, boundary promotion, counting.
            always_comb begin
                cnt_next   = cnt_reg;
                div_next   = div_reg;
                high_next  = high_reg;
                sdiv_next  = wr ? cfg.div  : sdiv_reg;
                shigh_next = wr ? cfg.high : shigh_reg;
                pend_next  = pend_reg;
                dclk_next  = dclk_reg;
                tick_next  = 1'b0;
                if (bnd) begin
                    // Same-cycle write is the newest value, then the shadow.
                    div_next  = wr ? cfg.div  : (pend_reg ? sdiv_reg  : div_reg);
                    high_next = wr ? cfg.high : (pend_reg ? shigh_reg : high_reg);
                    pend_next = 1'b0;
                    cnt_next  = '0;
                    tick_next = (div_next != '0);
                    dclk_next = (div_next != '0) && (high_next != '0);
                end else begin
                    if (wr) begin
                        pend_next = 1'b1;
                    end
                    if (en_i[gi]) begin
                        cnt_next  = cnt_inc;
                        dclk_next = (cnt_inc < high_reg);
                    end
                end
            end

            // State register with asynchronous return to the reset config.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    cnt_reg   <= RST_CNT_V;
                    div_reg   <= RST_DIV_V;
                    high_reg  <= RST_HI_V;
                    sdiv_reg  <= '0;
                    shigh_reg <= '0;
                    pend_reg  <= 1'b0;
                    dclk_reg  <= 1'b0;
                    tick_reg  <= 1'b0;
                end else begin
                    cnt_reg   <= cnt_next;
                    div_reg   <= div_next;
                    high_reg  <= high_next;
                    sdiv_reg  <= sdiv_next;
                    shigh_reg <= shigh_next;
                    pend_reg  <= pend_next;
                    dclk_reg  <= dclk_next;
                    tick_reg  <= tick_next;
                end
            end

            assign dclk_o[gi]   = dclk_reg;
            assign tick_o[gi]   = tick_reg;
            assign cfg.pend[gi] = pend_reg;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed testbench for clk_div_multi (4 channels, 8-bit counters, reset 2/1).
module tb_clk_div_multi;

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic [3:0] en_i   = '0;
    logic       sync_i = 1'b0;
    logic [3:0] dclk_o;
    logic [3:0] tick_o;

    int n_pass  = 0;
    int n_total = 0;

    clk_div_multi_if #(.NUM_CH(4), .CNT_WIDTH(8)) cfg_if ();

    clk_div_multi #(
        .NUM_CH(4), .CNT_WIDTH(8), .RST_DIV(2), .RST_HIGH(1)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .cfg    (cfg_if.slave),
        .en_i   (en_i),
        .sync_i (sync_i),
        .dclk_o (dclk_o),
        .tick_o (tick_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] en;
        logic       sync;
        logic       we;
        logic [1:0] ch;
        logic [7:0] div;
        logic [7:0] high;
        logic [3:0] dclk;
        logic [3:0] tick;
        logic [3:0] pend;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    // Drive one cycle of inputs, clock it, and sample 1ns after the edge.
    task automatic step(input logic [3:0] en, input logic sync, input logic we,
                        input logic [1:0] ch, input logic [7:0] dv, input logic [7:0] hi);
        en_i        = en;
        sync_i      = sync;
        cfg_if.we   = we;
        cfg_if.ch   = ch;
        cfg_if.div  = dv;
        cfg_if.high = hi;
        @(posedge clk_i);
        #1;
        cfg_if.we = 1'b0;
        sync_i    = 1'b0;
    endtask

    task automatic step_chk(input string name, input logic [3:0] en, input logic sync,
                            input logic we, input logic [1:0] ch, input logic [7:0] dv,
                            input logic [7:0] hi, input logic [3:0] e_dclk,
                            input logic [3:0] e_tick, input logic [3:0] e_pend);
        step(en, sync, we, ch, dv, hi);
        $display("txn %s: dclk=%b tick=%b pend=%b", name, dclk_o, tick_o, cfg_if.pend);
        chk({name, ".dclk"}, dclk_o, e_dclk);
        chk({name, ".tick"}, tick_o, e_tick);
        chk({name, ".pend"}, cfg_if.pend, e_pend);
    endtask

    task automatic do_reset();
        en_i = '0; sync_i = 1'b0;
        cfg_if.we = 1'b0; cfg_if.ch = '0; cfg_if.div = '0; cfg_if.high = '0;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Tests 1 and 2: defaults on all channels, then ch0 reprogrammed to 5/2.
        tbl[0]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'hF, 4'hF, 4'h0};
        tbl[1]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h0, 4'h0, 4'h0};
        tbl[2]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'hF, 4'hF, 4'h0};
        tbl[3]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h0, 4'h0, 4'h0};
        tbl[4]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'hF, 4'hF, 4'h0};
        tbl[5]  = '{4'hF, 1'b0, 1'b1, 2'd0, 8'd5, 8'd2, 4'h0, 4'h0, 4'h1};
        tbl[6]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'hF, 4'hF, 4'h0};
        tbl[7]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h1, 4'h0, 4'h0};
        tbl[8]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'hE, 4'hE, 4'h0};
        tbl[9]  = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h0, 4'h0, 4'h0};
        tbl[10] = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'hE, 4'hE, 4'h0};
        tbl[11] = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h1, 4'h1, 4'h0};
        tbl[12] = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'hF, 4'hE, 4'h0};
        tbl[13] = '{4'hF, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h0, 4'h0, 4'h0};

        do_reset();
        chk("reset.dclk", dclk_o, 4'h0);
        chk("reset.tick", tick_o, 4'h0);
        chk("reset.pend", cfg_if.pend, 4'h0);

        for (int i = 0; i < 14; i++) begin
            step_chk($sformatf("tbl%0d", i), tbl[i].en, tbl[i].sync, tbl[i].we, tbl[i].ch,
                     tbl[i].div, tbl[i].high, tbl[i].dclk, tbl[i].tick, tbl[i].pend);
        end

        // Test 3: ch1 stopped via pending D=0, then restarted with 3/3.
        do_reset();
        step_chk("t3.wr0",   4'h0, 1'b0, 1'b1, 2'd1, 8'd0, 8'd0, 4'h0, 4'h0, 4'h2);
        step_chk("t3.stop",  4'h2, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h0, 4'h0, 4'h0);
        step_chk("t3.hold1", 4'h2, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h0, 4'h0, 4'h0);
        step_chk("t3.hold2", 4'h2, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h0, 4'h0, 4'h0);
        step_chk("t3.wr3",   4'h0, 1'b0, 1'b1, 2'd1, 8'd3, 8'd3, 4'h0, 4'h0, 4'h2);
        step_chk("t3.start", 4'h2, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h2, 4'h2, 4'h0);
        step_chk("t3.c1",    4'h2, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h2, 4'h0, 4'h0);
        step_chk("t3.c2",    4'h2, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h2, 4'h0, 4'h0);
        step_chk("t3.tick2", 4'h2, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h2, 4'h2, 4'h0);
        step_chk("t3.c4",    4'h2, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h2, 4'h0, 4'h0);

        // Tests 4 and 6a: write on a boundary applies at once; enable gap stretches period.
        do_reset();
        step_chk("t4.wrbnd", 4'h4, 1'b0, 1'b1, 2'd2, 8'd4, 8'd2, 4'h4, 4'h4, 4'h0);
        step_chk("t4.c1",    4'h4, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h4, 4'h0, 4'h0);
        step_chk("t4.gap1",  4'h0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h4, 4'h0, 4'h0);
        step_chk("t4.gap2",  4'h0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h4, 4'h0, 4'h0);
        step_chk("t4.gap3",  4'h0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h4, 4'h0, 4'h0);
        step_chk("t4.c2",    4'h4, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h0, 4'h0, 4'h0);
        step_chk("t4.c3",    4'h4, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h0, 4'h0, 4'h0);
        step_chk("t4.tick",  4'h4, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h4, 4'h4, 4'h0);

        // Test 5: ch0 3/1 and ch1 4/2 brought into phase by sync (en low on the sync cycle).
        do_reset();
        step_chk("t5.wr0",  4'h3, 1'b0, 1'b1, 2'd0, 8'd3, 8'd1, 4'h3, 4'h3, 4'h0);
        step_chk("t5.wr1",  4'h3, 1'b0, 1'b1, 2'd1, 8'd4, 8'd2, 4'h0, 4'h0, 4'h2);
        step_chk("t5.ld1",  4'h3, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h2, 4'h2, 4'h0);
        step_chk("t5.run",  4'h3, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h3, 4'h1, 4'h0);
        step_chk("t5.sync", 4'h0, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 4'hF, 4'hF, 4'h0);
        for (int k = 1; k <= 12; k++) begin
            logic [3:0] e_tick;
            logic [3:0] e_dclk;
            e_tick = {2'b00, (k % 4 == 0), (k % 3 == 0)};
            e_dclk = {2'b11, (k % 4 < 2), (k % 3 == 0)};
            step_chk($sformatf("t5.k%0d", k), 4'h3, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0,
                     e_dclk, e_tick, 4'h0);
        end

        // Test 6b: async reset mid-period discards a pending write.
        step_chk("t6.pend", 4'h3, 1'b0, 1'b1, 2'd3, 8'd7, 8'd7, 4'hE, 4'h0, 4'h8);
        #2;
        rst_ni = 1'b0;
        #1;
        $display("txn t6.rst: dclk=%b tick=%b pend=%b", dclk_o, tick_o, cfg_if.pend);
        chk("t6.rst.dclk", dclk_o, 4'h0);
        chk("t6.rst.tick", tick_o, 4'h0);
        chk("t6.rst.pend", cfg_if.pend, 4'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        step_chk("t6.first", 4'h8, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h8, 4'h8, 4'h0);
        step_chk("t6.dflt",  4'h8, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 4'h0, 4'h0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
